// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- operand, MT-write and HI/LO result bundle of the
// iterative multiply/divide unit. The issuing stage uses the master modport,
// the unit itself the slave modport.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, input1, input2, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, input1, input2, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Sequence: IDLE -> LOAD -> CALC (one bit per cycle, 32 cycles) -> FIX -> IDLE.
// Optional feature macro MULDIV_DIV_EN: when defined the restoring divider is
// built; when undefined a DIV/DIVU goes IDLE -> FIX, leaves HI/LO untouched and
// reports div_by_zero=0.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

  // Two's-complement magnitude; 0x80..0 maps to itself and is then read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] m;
    if (x[WIDTH-1]) begin
      m = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = x;
    end
    return m;
  endfunction

  state_t             state_r, state_next_s;
  logic               busy_r, done_r, dbz_r;
  logic               busy_next_s, done_next_s;
  logic               capture_s, load_s, calc_s, fix_s;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   in1_r, in2_r;      // operands as presented with start
  logic [WIDTH-1:0]   a_r;               // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_r;             // {upper, lower} working accumulator
  logic [4:0]         cnt_r;
  logic               neg_r;             // product / quotient sign
  logic [WIDTH-1:0]   opa_s, opb_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [2*WIDTH-1:0] prod_s;
`ifdef MULDIV_DIV_EN
  logic               rem_neg_r;         // remainder follows the dividend sign
  logic               dbz_pend_r;        // current divide has a zero divisor
  logic [WIDTH:0]     div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [WIDTH-1:0]   div_hi_s, div_lo_s;
`endif

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start is only looked at while idle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
`ifdef MULDIV_DIV_EN
          state_next_s = S_LOAD;
`else
          if (bus.op[1]) begin
            state_next_s = S_FIX;
          end else begin
            state_next_s = S_LOAD;
          end
`endif
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD: state_next_s = S_CALC;
      S_CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = S_FIX;
        end else begin
          state_next_s = S_CALC;
        end
      end
      S_FIX:   state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Output and datapath-enable decode; busy/done are registered from here.
  always_comb begin
    busy_next_s = (state_next_s != S_IDLE);
    done_next_s = (state_r == S_FIX);
    capture_s   = (state_r == S_IDLE) && bus.start;
    load_s      = (state_r == S_LOAD);
    calc_s      = (state_r == S_CALC);
    fix_s       = (state_r == S_FIX);
  end

  // Operand selection, iteration steps and sign fix-up.
  always_comb begin
    opa_s      = op_r[0] ? in1_r : magnitude(in1_r);
    opb_s      = op_r[0] ? in2_r : magnitude(in2_r);
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                 (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    prod_s     = neg_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
`ifdef MULDIV_DIV_EN
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, a_r};
    if (!div_diff_s[WIDTH]) begin
      div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
    if (dbz_pend_r) begin
      div_lo_s = {WIDTH{1'b1}};
      div_hi_s = in1_r;
    end else begin
      div_lo_s = neg_r ? (~acc_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                       : acc_r[WIDTH-1:0];
      div_hi_s = rem_neg_r ? (~acc_r[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                           : acc_r[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Operand capture at start, LOAD set-up, then one bit per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r       <= 2'b00;
      in1_r      <= {WIDTH{1'b0}};
      in2_r      <= {WIDTH{1'b0}};
      a_r        <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      cnt_r      <= 5'd0;
      neg_r      <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_neg_r  <= 1'b0;
      dbz_pend_r <= 1'b0;
`endif
    end else begin
      if (capture_s) begin
        op_r  <= bus.op;
        in1_r <= bus.input1;
        in2_r <= bus.input2;
      end
      if (load_s) begin
        cnt_r <= 5'd0;
        neg_r <= ~op_r[0] & (in1_r[WIDTH-1] ^ in2_r[WIDTH-1]);
        if (op_r[1]) begin
          a_r   <= opb_s;
          acc_r <= {{WIDTH{1'b0}}, opa_s};
        end else begin
          a_r   <= opa_s;
          acc_r <= {{WIDTH{1'b0}}, opb_s};
        end
`ifdef MULDIV_DIV_EN
        rem_neg_r  <= ~op_r[0] & in1_r[WIDTH-1];
        dbz_pend_r <= op_r[1] & (in2_r == {WIDTH{1'b0}});
`endif
      end else if (calc_s) begin
        cnt_r <= cnt_r + 5'd1;
`ifdef MULDIV_DIV_EN
        if (op_r[1]) begin
          acc_r <= div_next_s;
        end else begin
          acc_r <= mul_next_s;
        end
`else
        acc_r <= mul_next_s;
`endif
      end
    end
  end

  // Architectural HI/LO: FIX result, otherwise MTHI/MTLO while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (fix_s) begin
      if (!op_r[1]) begin
        hi_r <= prod_s[2*WIDTH-1:WIDTH];
        lo_r <= prod_s[WIDTH-1:0];
      end else begin
`ifdef MULDIV_DIV_EN
        hi_r <= div_hi_s;
        lo_r <= div_lo_s;
`else
        hi_r <= hi_r;
        lo_r <= lo_r;
`endif
      end
    end else if (!busy_r) begin
      if (bus.hi_we) begin
        hi_r <= bus.wdata;
      end
      if (bus.lo_we) begin
        lo_r <= bus.wdata;
      end
    end
  end

  // Status flags: busy, single-cycle done, div_by_zero refreshed on each done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
      if (fix_s) begin
`ifdef MULDIV_DIV_EN
        dbz_r <= dbz_pend_r;
`else
        dbz_r <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- scoreboard bench: each launch pushes its hand-computed
// result and latency; a monitor compares whenever done pulses.
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic        prev_done = 1'b0;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every done, and make sure done is one cycle wide.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (prev_done) check("done_width", 32'(bus.done), 32'd0);
      if (bus.done === 1'b1 && !prev_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("hi", bus.hi, e.hi);
          check("lo", bus.lo, e.lo);
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
          check("latency", 32'(cyc - e.issue), 32'(e.lat));
          check("busy_at_done", 32'(bus.busy), 32'd0);
        end
      end
    end
    prev_done <= bus.done;
  end

  // Issue one operation from a negedge; returns at the negedge of cycle 1.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    exp_t e;
    int   lat;
    lat = 35;
`ifndef MULDIV_DIV_EN
    if (op[1]) begin
      eh  = m_hi;
      el  = m_lo;
      ed  = 1'b0;
      lat = 2;
    end
`endif
    bus.op     = op;
    bus.input1 = a;
    bus.input2 = b;
    bus.start  = 1'b1;
    e.hi = eh; e.lo = el; e.dbz = ed; e.lat = lat; e.issue = cyc;
    sb_q.push_back(e);
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op     = ~op;
    bus.input1 = 32'hA5A5A5A5;
    bus.input2 = 32'h5A5A5A5A;
    check("busy_cycle1", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] old_hi;
    int n;
    bus.start = 1'b0; bus.op = 2'b00; bus.input1 = 32'h0; bus.input2 = 32'h0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Multiplies and divides from the test plan.
    launch(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0); wait_done();
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0); wait_done();
    launch(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0); wait_done();
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0); wait_done();
    launch(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0); wait_done();
    launch(2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1); wait_done();
    launch(2'b01, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0); wait_done();
    launch(2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1); wait_done();
    launch(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0); wait_done();

    // start and hi_we during busy are ignored.
    old_hi = bus.hi;
    launch(2'b01, 32'd7, 32'd9, 32'h0, 32'd63, 1'b0);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.input1 = 32'd1000; bus.input2 = 32'd1000;
    bus.hi_we = 1'b1; bus.wdata = 32'h00000BAD;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    check("hi_we_busy", bus.hi, old_hi);
    check("busy_mid", 32'(bus.busy), 32'd1);
    wait_done();

    // MT writes while idle.
    bus.lo_we = 1'b1; bus.wdata = 32'h00001234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    m_lo = 32'h00001234;
    check("mtlo_lo", bus.lo, m_lo);
    check("mtlo_hi", bus.hi, m_hi);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h000055AA;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    m_hi = 32'h000055AA; m_lo = 32'h000055AA;
    check("mt_both_hi", bus.hi, m_hi);
    check("mt_both_lo", bus.lo, m_lo);

    // start with an MTLO in the same idle cycle: MT lands, FIX overwrites it.
    bus.lo_we = 1'b1; bus.wdata = 32'h00000777;
    launch(2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);
    bus.lo_we = 1'b0;
    check("mt_with_start", bus.lo, 32'h00000777);
    wait_done();

    // Back-to-back: next start issued in the done cycle.
    launch(2'b01, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0);
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 32'(bus.done), 32'd1);
    launch(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done();

    // Reset in the middle of an operation.
    bus.hi_we = 1'b1; bus.wdata = 32'h0000CAFE;
    @(negedge clk);
    bus.hi_we = 1'b0;
    m_hi = 32'h0000CAFE;
    check("mthi_pre_reset", bus.hi, m_hi);
`ifdef MULDIV_DIV_EN
    launch(2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
`else
    launch(2'b01, 32'd1000, 32'd3, 32'd0, 32'd3000, 1'b0);
`endif
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_hi", bus.hi, 32'h0);
    check("midrst_lo", bus.lo, 32'h0);
    sb_q.delete();
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_hi", bus.hi, 32'h0);
    launch(2'b00, 32'd4, 32'd4, 32'h0, 32'd16, 1'b0); wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
